mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the instruction-fetch (IF) requester and the data-access (MEM stage) requester.
- Serialises accesses through a small FSM with a parameterised memory latency.
- Returns read data per requester and drives per-requester stall lines so the pipeline freezes until its access completes.
- Sits between the IF/MEM pipeline stages and the memory macro.

---
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported unified memory between the instruction-fetch
// requester (IF) and the data-access requester (MEM stage). Accesses are
// serialised through an IDLE -> ACCESS -> DONE sequence. ACCESS lasts LAT
// cycles. Each requester gets its own read-data register, completion pulse
// and stall line.
//
// Build option:
//   ARC_MEM_ARB_RR_EN  defined   -> round-robin arbitration on conflicts
//                      undefined -> fixed priority, data port wins
//
// Ports:
//   i_clk, i_rst            clock (rising edge), async active-high reset
//   i_if_req/i_if_addr      fetch request (held until o_if_valid), address
//   o_if_rdata/o_if_valid   registered fetch data, one-cycle completion pulse
//   o_if_stall              fetch stall (request pending, not yet completed)
//   i_mem_req/i_mem_we      data request (held until o_mem_valid), write flag
//   i_mem_addr/i_mem_wdata  data address, write data
//   o_mem_rdata/o_mem_valid registered load data, one-cycle completion pulse
//   o_mem_stall             data stall
//   o_ram_*                 memory macro interface, zero outside ACCESS
//   i_ram_rdata             memory read data, valid in the last ACCESS cycle
//   o_grant_mem             current or last grant went to the data port
//
// state  | meaning
// IDLE   | waiting for a request; arbitrates and latches the access
// ACCESS | memory busy for LAT cycles; enable only in the first cycle
// DONE   | owner's valid pulse; no request is sampled here
module mem_port_arbiter #(
   parameter int LAT = 2,
   parameter int AW  = 32,
   parameter int DW  = 32
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_if_req,
   input  logic [AW-1:0] i_if_addr,
   output logic [DW-1:0] o_if_rdata,
   output logic          o_if_valid,
   output logic          o_if_stall,
   input  logic          i_mem_req,
   input  logic          i_mem_we,
   input  logic [AW-1:0] i_mem_addr,
   input  logic [DW-1:0] i_mem_wdata,
   output logic [DW-1:0] o_mem_rdata,
   output logic          o_mem_valid,
   output logic          o_mem_stall,
   output logic          o_ram_en,
   output logic          o_ram_we,
   output logic [AW-1:0] o_ram_addr,
   output logic [DW-1:0] o_ram_wdata,
   input  logic [DW-1:0] i_ram_rdata,
   output logic          o_grant_mem
);

   localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic            owner_mem;
   logic            grant_mem;
   logic            lat_we;
   logic [AW-1:0]   lat_addr;
   logic [DW-1:0]   lat_wdata;
   logic [DW-1:0]   if_rdata;
   logic [DW-1:0]   mem_rdata;
   logic            any_req;
   logic            pick_mem;
   logic            first_cycle;
   logic            last_cycle;
   logic            if_valid;
   logic            mem_valid;

   assign any_req     = i_if_req | i_mem_req;
   assign first_cycle = (cnt == CW'(LAT - 1));
   assign last_cycle  = (cnt == '0);

   // grant_mem doubles as the last-grant flag: 0 after reset means IF was
   // granted last, so the data port wins the first round-robin conflict.
`ifdef ARC_MEM_ARB_RR_EN
   assign pick_mem = i_mem_req & (~i_if_req | ~grant_mem);
`else
   assign pick_mem = i_mem_req;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (any_req) state_nxt = ST_ACCESS;
         ST_ACCESS: if (last_cycle) state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      o_ram_en    = 1'b0;
      o_ram_we    = 1'b0;
      o_ram_addr  = '0;
      o_ram_wdata = '0;
      if_valid    = 1'b0;
      mem_valid   = 1'b0;
      case (state)
         ST_ACCESS: begin
            o_ram_en    = first_cycle;
            o_ram_we    = lat_we;
            o_ram_addr  = lat_addr;
            o_ram_wdata = lat_wdata;
         end
         ST_DONE: begin
            if_valid  = ~owner_mem;
            mem_valid = owner_mem;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt       <= '0;
         owner_mem <= 1'b0;
         grant_mem <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         if_rdata  <= '0;
         mem_rdata <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  owner_mem <= pick_mem;
                  grant_mem <= pick_mem;
                  lat_we    <= pick_mem & i_mem_we;
                  lat_addr  <= pick_mem ? i_mem_addr : i_if_addr;
                  lat_wdata <= pick_mem ? i_mem_wdata : '0;
                  cnt       <= CW'(LAT - 1);
               end
            end
            ST_ACCESS: begin
               if (!last_cycle) begin
                  cnt <= cnt - CW'(1);
               end else if (!lat_we) begin
                  if (owner_mem) mem_rdata <= i_ram_rdata;
                  else           if_rdata  <= i_ram_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_if_rdata  = if_rdata;
   assign o_mem_rdata = mem_rdata;
   assign o_if_valid  = if_valid;
   assign o_mem_valid = mem_valid;
   assign o_grant_mem = grant_mem;

   // Stalls are masked while reset is asserted so every output reads 0 then,
   // even if a requester keeps its request line high through reset.
   assign o_if_stall  = i_if_req  & ~if_valid  & ~i_rst;
   assign o_mem_stall = i_mem_req & ~mem_valid & ~i_rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_if_req;
   logic [31:0] i_if_addr;
   logic [31:0] o_if_rdata;
   logic        o_if_valid;
   logic        o_if_stall;
   logic        i_mem_req;
   logic        i_mem_we;
   logic [31:0] i_mem_addr;
   logic [31:0] i_mem_wdata;
   logic [31:0] o_mem_rdata;
   logic        o_mem_valid;
   logic        o_mem_stall;
   logic        o_ram_en;
   logic        o_ram_we;
   logic [31:0] o_ram_addr;
   logic [31:0] o_ram_wdata;
   logic [31:0] i_ram_rdata;
   logic        o_grant_mem;

   int checks   = 0;
   int failures = 0;

   // Small memory model with one-cycle read latency: enable in the first
   // ACCESS cycle, data present in the second (last) ACCESS cycle.
   // Index {addr[12], addr[2]}: 0x40->0, 0x44->1, 0x1000->2, 0x1004->3.
   logic [31:0] ram [4];

   always #5 i_clk = ~i_clk;

   mem_port_arbiter #(.LAT(2), .AW(32), .DW(32)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_if_req    (i_if_req),
      .i_if_addr   (i_if_addr),
      .o_if_rdata  (o_if_rdata),
      .o_if_valid  (o_if_valid),
      .o_if_stall  (o_if_stall),
      .i_mem_req   (i_mem_req),
      .i_mem_we    (i_mem_we),
      .i_mem_addr  (i_mem_addr),
      .i_mem_wdata (i_mem_wdata),
      .o_mem_rdata (o_mem_rdata),
      .o_mem_valid (o_mem_valid),
      .o_mem_stall (o_mem_stall),
      .o_ram_en    (o_ram_en),
      .o_ram_we    (o_ram_we),
      .o_ram_addr  (o_ram_addr),
      .o_ram_wdata (o_ram_wdata),
      .i_ram_rdata (i_ram_rdata),
      .o_grant_mem (o_grant_mem)
   );

   always @(posedge i_clk) begin
      if (o_ram_en) begin
         if (o_ram_we) ram[{o_ram_addr[12], o_ram_addr[2]}] <= o_ram_wdata;
         else          i_ram_rdata <= ram[{o_ram_addr[12], o_ram_addr[2]}];
      end
   end

   task automatic test_reset();
      i_rst = 1'b1;
      i_if_req = 1'b0; i_if_addr = '0;
      i_mem_req = 1'b0; i_mem_we = 1'b0; i_mem_addr = '0; i_mem_wdata = '0;
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
      #1;
      checks++;
      if ({o_if_valid, o_mem_valid, o_if_stall, o_mem_stall, o_ram_en, o_ram_we, o_grant_mem} !== 7'b0) begin
         failures++;
         $display("FAIL reset_ctrl got %b want 0000000",
                  {o_if_valid, o_mem_valid, o_if_stall, o_mem_stall, o_ram_en, o_ram_we, o_grant_mem});
      end
      checks++;
      if ({o_if_rdata, o_mem_rdata, o_ram_addr, o_ram_wdata} !== 128'b0) begin
         failures++;
         $display("FAIL reset_data got %h %h %h %h want all 0", o_if_rdata, o_mem_rdata, o_ram_addr, o_ram_wdata);
      end
   endtask

   task automatic test_if_read();
      logic [7:0] en_m, addr_m, valid_m, stall_m;
      logic [31:0] exp_addr;
      en_m = 8'b0000_0010; addr_m = 8'b0000_0110; valid_m = 8'b0000_1000; stall_m = 8'b0000_0111;
      @(negedge i_clk);
      i_if_req = 1'b1; i_if_addr = 32'h0000_0040;
      for (int c = 0; c < 4; c++) begin
         if (c == 0) #1; else @(negedge i_clk);
         exp_addr = addr_m[c] ? 32'h40 : 32'h0;
         checks++;
         if (o_ram_en !== en_m[c] || o_ram_addr !== exp_addr) begin
            failures++;
            $display("FAIL if_read_ram cycle %0d got en=%b addr=%h want en=%b addr=%h", c, o_ram_en, o_ram_addr, en_m[c], exp_addr);
         end
         checks++;
         if (o_if_valid !== valid_m[c] || o_if_stall !== stall_m[c] || o_mem_valid !== 1'b0) begin
            failures++;
            $display("FAIL if_read_hs cycle %0d got valid=%b stall=%b mvalid=%b want %b %b 0", c, o_if_valid, o_if_stall, o_mem_valid, valid_m[c], stall_m[c]);
         end
      end
      checks++;
      if (o_if_rdata !== 32'h2002_0005) begin
         failures++;
         $display("FAIL if_read_data got %h want 20020005", o_if_rdata);
      end
      i_if_req = 1'b0;
   endtask

   task automatic test_conflict();
      logic [7:0] en_m, mvalid_m, ivalid_m, istall_m, mstall_m, grant_m;
      logic [31:0] exp_addr;
      en_m = 8'b0010_0010; mvalid_m = 8'b0000_1000; ivalid_m = 8'b1000_0000;
      istall_m = 8'b0111_1111; mstall_m = 8'b0000_0111; grant_m = 8'b0001_1110;
      @(negedge i_clk);
      i_if_req = 1'b1; i_if_addr = 32'h44;
      i_mem_req = 1'b1; i_mem_we = 1'b0; i_mem_addr = 32'h1000;
      for (int c = 0; c < 8; c++) begin
         if (c == 0) #1; else @(negedge i_clk);
         exp_addr = (c == 1 || c == 2) ? 32'h1000 : (c == 5 || c == 6) ? 32'h44 : 32'h0;
         checks++;
         if (o_ram_en !== en_m[c] || o_ram_addr !== exp_addr || o_grant_mem !== grant_m[c]) begin
            failures++;
            $display("FAIL conflict_ram cycle %0d got en=%b addr=%h grant=%b want %b %h %b", c, o_ram_en, o_ram_addr, o_grant_mem, en_m[c], exp_addr, grant_m[c]);
         end
         checks++;
         if (o_mem_valid !== mvalid_m[c] || o_if_valid !== ivalid_m[c] ||
             o_mem_stall !== mstall_m[c] || o_if_stall !== istall_m[c]) begin
            failures++;
            $display("FAIL conflict_hs cycle %0d got mv=%b iv=%b ms=%b is=%b want %b %b %b %b", c, o_mem_valid, o_if_valid,
                     o_mem_stall, o_if_stall, mvalid_m[c], ivalid_m[c], mstall_m[c], istall_m[c]);
         end
         if (c == 3) begin
            checks++;
            if (o_mem_rdata !== 32'hAAAA_1000) begin
               failures++;
               $display("FAIL conflict_mem_data got %h want aaaa1000", o_mem_rdata);
            end
            i_mem_req = 1'b0;
         end
      end
      checks++;
      if (o_if_rdata !== 32'h1111_0044) begin
         failures++;
         $display("FAIL conflict_if_data got %h want 11110044", o_if_rdata);
      end
      i_if_req = 1'b0;
   endtask

   task automatic test_write();
      logic [3:0] we_m, valid_m;
      logic [31:0] exp_wd;
      we_m = 4'b0110; valid_m = 4'b1000;
      @(negedge i_clk);
      i_mem_req = 1'b1; i_mem_we = 1'b1; i_mem_addr = 32'h1004; i_mem_wdata = 32'hDEAD_BEEF;
      for (int c = 0; c < 4; c++) begin
         if (c == 0) #1; else @(negedge i_clk);
         exp_wd = we_m[c] ? 32'hDEAD_BEEF : 32'h0;
         checks++;
         if (o_ram_we !== we_m[c] || o_ram_wdata !== exp_wd || o_mem_valid !== valid_m[c]) begin
            failures++;
            $display("FAIL write cycle %0d got we=%b wd=%h valid=%b want %b %h %b", c, o_ram_we, o_ram_wdata, o_mem_valid, we_m[c], exp_wd, valid_m[c]);
         end
      end
      checks++;
      if (o_mem_rdata !== 32'hAAAA_1000) begin
         failures++;
         $display("FAIL write_rdata_hold got %h want aaaa1000", o_mem_rdata);
      end
      i_mem_req = 1'b0; i_mem_we = 1'b0; i_mem_wdata = '0;
   endtask

   task automatic test_abort();
      @(negedge i_clk);
      i_if_req = 1'b1; i_if_addr = 32'h40;
      repeat (2) @(negedge i_clk);
      i_rst = 1'b1;
      #1;
      checks++;
      if ({o_ram_en, o_ram_addr, o_if_valid, o_if_stall, o_grant_mem} !== 36'b0) begin
         failures++;
         $display("FAIL abort_outputs got en=%b addr=%h v=%b s=%b g=%b want all 0", o_ram_en, o_ram_addr, o_if_valid, o_if_stall, o_grant_mem);
      end
      checks++;
      if (o_if_rdata !== 32'h0 || o_mem_rdata !== 32'h0) begin
         failures++;
         $display("FAIL abort_rdata got %h %h want 0 0", o_if_rdata, o_mem_rdata);
      end
      @(negedge i_clk);
      i_if_req = 1'b0;
      i_rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge i_clk);
         checks++;
         if (o_if_valid !== 1'b0 || o_mem_valid !== 1'b0 || o_ram_en !== 1'b0) begin
            failures++;
            $display("FAIL abort_quiet cycle %0d got iv=%b mv=%b en=%b want 0 0 0", c, o_if_valid, o_mem_valid, o_ram_en);
         end
      end
      i_if_req = 1'b1; i_if_addr = 32'h44;
      repeat (3) @(negedge i_clk);
      checks++;
      if (o_if_valid !== 1'b1 || o_if_rdata !== 32'h1111_0044) begin
         failures++;
         $display("FAIL abort_recover got valid=%b data=%h want 1 11110044", o_if_valid, o_if_rdata);
      end
      i_if_req = 1'b0;
   endtask

   task automatic test_fairness();
      logic [15:0] mv_m, iv_m, is_m;
`ifdef ARC_MEM_ARB_RR_EN
      mv_m = 16'h0808; iv_m = 16'h8080; is_m = 16'h7F7F;
`else
      mv_m = 16'h8888; iv_m = 16'h0000; is_m = 16'hFFFF;
`endif
      @(negedge i_clk);
      i_if_req = 1'b1; i_if_addr = 32'h40;
      i_mem_req = 1'b1; i_mem_we = 1'b0; i_mem_addr = 32'h1000;
      for (int c = 0; c < 16; c++) begin
         if (c == 0) #1; else @(negedge i_clk);
         checks++;
         if (o_mem_valid !== mv_m[c] || o_if_valid !== iv_m[c] || o_if_stall !== is_m[c]) begin
            failures++;
            $display("FAIL fairness cycle %0d got mv=%b iv=%b is=%b want %b %b %b", c, o_mem_valid, o_if_valid, o_if_stall, mv_m[c], iv_m[c], is_m[c]);
         end
      end
      i_if_req = 1'b0; i_mem_req = 1'b0;
      @(negedge i_clk);
   endtask

   initial begin
      ram[0] = 32'h2002_0005;
      ram[1] = 32'h1111_0044;
      ram[2] = 32'hAAAA_1000;
      ram[3] = 32'h0000_0000;
      i_ram_rdata = '0;
      test_reset();
      test_if_read();
      test_conflict();
      test_write();
      test_abort();
      test_fairness();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
